// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: states, opcodes,
// function codes, ALU operation codes and datapath mux encodings.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC_R  = 4'd2,
        ST_EXEC_SH = 4'd3,
        ST_EXEC_I  = 4'd4,
        ST_ADDR    = 4'd5,
        ST_MEM_RD  = 4'd6,
        ST_MEM_WR  = 4'd7,
        ST_WB_R    = 4'd8,
        ST_WB_MEM  = 4'd9,
        ST_BRANCH  = 4'd10,
`ifdef JUMP_EN
        ST_JUMP    = 4'd11,
`endif
        ST_FAULT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SPEC2 = 6'h1C;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_MUL = 6'h02;
    localparam logic [5:0] FN_CLZ = 6'h20;
    localparam logic [5:0] FN_CLO = 6'h21;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_CMP = 4'd7;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_SRL = 4'd10;
    localparam logic [3:0] ALU_CLO = 4'd11;
    localparam logic [3:0] ALU_CLZ = 4'd12;

    localparam logic [1:0] BSEL_REG   = 2'd0;
    localparam logic [1:0] BSEL_FOUR  = 2'd1;
    localparam logic [1:0] BSEL_IMM   = 2'd2;
    localparam logic [1:0] BSEL_SHAMT = 2'd3;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    // State following DECODE; ST_FETCH marks an unsupported instruction.
    function automatic state_t decode_next(logic [5:0] op, logic [5:0] fn);
        state_t s;
        s = ST_FETCH;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: s = ST_EXEC_R;
                    FN_SLL, FN_SRL: s = ST_EXEC_SH;
                    default: s = ST_FETCH;
                endcase
            end
            OP_SPEC2: begin
                case (fn)
                    FN_CLO, FN_CLZ, FN_MUL: s = ST_EXEC_R;
                    default: s = ST_FETCH;
                endcase
            end
            OP_ADDI, OP_ORI: s = ST_EXEC_I;
            OP_LW, OP_SW: s = ST_ADDR;
            OP_BNE: s = ST_BRANCH;
`ifdef JUMP_EN
            OP_J: s = ST_JUMP;
`endif
            default: s = ST_FETCH;
        endcase
        return s;
    endfunction

    // ALU operation for the execute step of a latched instruction.
    function automatic logic [3:0] alu_code(logic [5:0] op, logic [5:0] fn);
        logic [3:0] c;
        c = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SUB: c = ALU_SUB;
                    FN_AND: c = ALU_AND;
                    FN_OR:  c = ALU_OR;
                    FN_SLT: c = ALU_SLT;
                    FN_SLL: c = ALU_SLL;
                    FN_SRL: c = ALU_SRL;
                    default: c = ALU_ADD;
                endcase
            end
            OP_SPEC2: begin
                case (fn)
                    FN_MUL: c = ALU_MUL;
                    FN_CLO: c = ALU_CLO;
                    FN_CLZ: c = ALU_CLZ;
                    default: c = ALU_ADD;
                endcase
            end
            OP_ORI: c = ALU_OR;
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts cycles without acknowledge and flags
// expiry on the MEM_TIMEOUT-th consecutive unacknowledged cycle.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    logic [7:0] cnt;

    // Count unacknowledged wait cycles; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expire = inc && (cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM with memory timeout fault.
// Define JUMP_EN to support the jump instruction (opcode 0x02).
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ack,
    output logic               ir_write,
    output logic               pc_write,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         state_o,
    output logic               illegal,
    output logic               fault
);

    state_t     state;
    state_t     state_nx;
    state_t     dec_nx;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic [3:0] code;
    logic [3:0] alu_op_c;
    logic       waiting;
    logic       expire;

    assign dec_nx  = decode_next(opcode, func);
    assign code    = alu_code(op_q, fn_q);
    assign waiting = (state == ST_FETCH) || (state == ST_MEM_RD) ||
                     (state == ST_MEM_WR);

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!waiting || mem_ack),
        .inc    (waiting && !mem_ack),
        .expire (expire)
    );

    // State register and instruction fields captured while decoding.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
            op_q  <= '0;
            fn_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_DECODE) begin
                op_q <= opcode;
                fn_q <= func;
            end
        end
    end

    // Next-state selection; acknowledge takes priority over timeout.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_FETCH: begin
                if (mem_ack)     state_nx = ST_DECODE;
                else if (expire) state_nx = ST_FAULT;
            end
            ST_DECODE:  state_nx = dec_nx;
            ST_EXEC_R,
            ST_EXEC_SH,
            ST_EXEC_I:  state_nx = ST_WB_R;
            ST_ADDR:    state_nx = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ack)     state_nx = ST_WB_MEM;
                else if (expire) state_nx = ST_FAULT;
            end
            ST_MEM_WR: begin
                if (mem_ack)     state_nx = ST_FETCH;
                else if (expire) state_nx = ST_FAULT;
            end
            ST_WB_R,
            ST_WB_MEM,
`ifdef JUMP_EN
            ST_JUMP,
`endif
            ST_BRANCH:  state_nx = ST_FETCH;
            ST_FAULT:   state_nx = ST_FAULT;
            default:    state_nx = ST_FETCH;
        endcase
    end

    // Datapath controls per state; all quiet while reset is held.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = BSEL_REG;
        pc_src     = PC_SEQ;
        alu_op_c   = ALU_ADD;
        illegal    = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = BSEL_FOUR;
                    if (mem_ack) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_DECODE: illegal = (dec_nx == ST_FETCH);
                ST_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op_c  = code;
                end
                ST_EXEC_SH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = BSEL_SHAMT;
                    alu_op_c  = code;
                end
                ST_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = BSEL_IMM;
                    alu_op_c  = code;
                end
                ST_WB_R: begin
                    reg_write = 1'b1;
                    reg_dst   = (op_q == OP_RTYPE) || (op_q == OP_SPEC2);
                end
                ST_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = BSEL_IMM;
                end
                ST_MEM_RD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                ST_MEM_WR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op_c  = ALU_CMP;
                    if (!zero) begin
                        pc_write = 1'b1;
                        pc_src   = PC_BRANCH;
                    end
                end
`ifdef JUMP_EN
                ST_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                end
`endif
                default: ;
            endcase
        end
    end

    assign alu_op  = ALUOP_W'(alu_op_c);
    assign state_o = state;
    assign fault   = (state == ST_FAULT);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus queues per-cycle
// expected outputs, a monitor on the falling edge pops and compares.
module tb_multicycle_controller;
    import mc_pkg::*;

    localparam logic [8:0] IRW  = 9'h100;
    localparam logic [8:0] PCW  = 9'h080;
    localparam logic [8:0] IORD = 9'h040;
    localparam logic [8:0] MRD  = 9'h020;
    localparam logic [8:0] MWR  = 9'h010;
    localparam logic [8:0] RGW  = 9'h008;
    localparam logic [8:0] RDST = 9'h004;
    localparam logic [8:0] M2R  = 9'h002;
    localparam logic [8:0] ASA  = 9'h001;

    typedef struct {
        string      nm;
        state_t     st;
        logic [8:0] stb;
        logic [1:0] sb;
        logic [1:0] ps;
        logic [3:0] ao;
        logic       ill;
        logic       flt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       ir_write, pc_write, iord, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [3:0] alu_op, state_o;
    logic       illegal, fault;

    exp_t q[$];
    int   pass_cnt = 0;
    int   total = 0;

    multicycle_controller #(.ALUOP_W(4), .MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .func       (func),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .state_o    (state_o),
        .illegal    (illegal),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] got,
                       input logic [3:0] want);
        total++;
        if (got !== want)
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        else
            pass_cnt++;
    endtask

    task automatic tick(input string nm, input state_t st,
                        input logic [8:0] stb, input logic [1:0] sb,
                        input logic [1:0] ps, input logic [3:0] ao,
                        input logic ill, input logic flt);
        q.push_back('{nm, st, stb, sb, ps, ao, ill, flt});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn,
                                input logic ill);
        opcode  = op;
        func    = fn;
        mem_ack = 1'b1;
        tick($sformatf("fetch_%0h_%0h", op, fn), ST_FETCH,
             IRW | PCW | MRD, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0);
        mem_ack = 1'b0;
        tick($sformatf("decode_%0h_%0h", op, fn), ST_DECODE,
             9'h0, 2'd0, 2'd0, 4'd0, ill, 1'b0);
    endtask

    // Monitor: compare every presented cycle against the queued record.
    initial begin
        exp_t       e;
        logic [8:0] stb;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                stb = {ir_write, pc_write, iord, mem_read, mem_write,
                       reg_write, reg_dst, mem_to_reg, alu_src_a};
                total++;
                if (state_o !== 4'(e.st) || stb !== e.stb ||
                    alu_src_b !== e.sb || pc_src !== e.ps ||
                    alu_op !== e.ao || illegal !== e.ill ||
                    fault !== e.flt) begin
                    $display({"FAIL %s: got st=%0d stb=%b srcb=%0d ",
                              "pcsrc=%0d aluop=%0d ill=%b flt=%b; want ",
                              "st=%0d stb=%b srcb=%0d pcsrc=%0d aluop=%0d ",
                              "ill=%b flt=%b"},
                             e.nm, state_o, stb, alu_src_b, pc_src, alu_op,
                             illegal, fault, 4'(e.st), e.stb, e.sb, e.ps,
                             e.ao, e.ill, e.flt);
                end else begin
                    pass_cnt++;
                end
            end
        end
    end

    // Stimulus: directed instruction sequences.
    initial begin
        @(posedge clk);
        #1;
        tick("reset0", ST_FETCH, 9'h0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        mem_ack = 1'b1;
        tick("reset1", ST_FETCH, 9'h0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        chk("rst_state", state_o, 4'(ST_FETCH));
        chk("rst_fault", {3'b0, fault}, 4'd0);
        chk("rst_mrd", {3'b0, mem_read}, 4'd0);
        chk("rst_aluop", alu_op, 4'd0);
        rst = 1'b0;

        // add
        fetch_decode(6'h00, 6'h20, 1'b0);
        tick("add_ex", ST_EXEC_R, ASA, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        tick("add_wb", ST_WB_R, RGW | RDST, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);

        // ori
        fetch_decode(6'h0D, 6'h00, 1'b0);
        tick("ori_ex", ST_EXEC_I, ASA, 2'd2, 2'd0, 4'd4, 1'b0, 1'b0);
        tick("ori_wb", ST_WB_R, RGW, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);

        // fetch wait then sll
        mem_ack = 1'b0;
        tick("fetch_wait", ST_FETCH, MRD, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0);
        fetch_decode(6'h00, 6'h00, 1'b0);
        tick("sll_ex", ST_EXEC_SH, ASA, 2'd3, 2'd0, 4'd8, 1'b0, 1'b0);
        tick("sll_wb", ST_WB_R, RGW | RDST, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);

        // clz
        fetch_decode(6'h1C, 6'h20, 1'b0);
        tick("clz_ex", ST_EXEC_R, ASA, 2'd0, 2'd0, 4'd12, 1'b0, 1'b0);
        tick("clz_wb", ST_WB_R, RGW | RDST, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);

        // lw with ack in the fourth MEM_RD cycle: 8 cycles total
        fetch_decode(6'h23, 6'h00, 1'b0);
        tick("lw_addr", ST_ADDR, ASA, 2'd2, 2'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            tick($sformatf("lw_wait%0d", i), ST_MEM_RD, IORD | MRD,
                 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        mem_ack = 1'b1;
        tick("lw_ack", ST_MEM_RD, IORD | MRD, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        mem_ack = 1'b0;
        tick("lw_wb", ST_WB_MEM, RGW | M2R, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);

        // bne taken then not taken
        zero = 1'b0;
        fetch_decode(6'h05, 6'h00, 1'b0);
        tick("bne_z0", ST_BRANCH, ASA | PCW, 2'd0, 2'd1, 4'd7, 1'b0, 1'b0);
        fetch_decode(6'h05, 6'h00, 1'b0);
        zero = 1'b1;
        tick("bne_z1", ST_BRANCH, ASA, 2'd0, 2'd0, 4'd7, 1'b0, 1'b0);
        zero = 1'b0;

        // illegal opcode, then jump opcode
        fetch_decode(6'h3F, 6'h00, 1'b1);
`ifdef JUMP_EN
        fetch_decode(6'h02, 6'h00, 1'b0);
        tick("jump", ST_JUMP, PCW, 2'd0, 2'd2, 4'd0, 1'b0, 1'b0);
`else
        fetch_decode(6'h02, 6'h00, 1'b1);
`endif

        // sw with immediate ack
        fetch_decode(6'h2B, 6'h00, 1'b0);
        tick("sw_addr", ST_ADDR, ASA, 2'd2, 2'd0, 4'd0, 1'b0, 1'b0);
        mem_ack = 1'b1;
        tick("sw_ack", ST_MEM_WR, IORD | MWR, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);

        // sw with ack on the timeout cycle: transfer completes
        fetch_decode(6'h2B, 6'h00, 1'b0);
        tick("sw2_addr", ST_ADDR, ASA, 2'd2, 2'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            tick($sformatf("sw2_wait%0d", i), ST_MEM_WR, IORD | MWR,
                 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        mem_ack = 1'b1;
        tick("sw2_ack", ST_MEM_WR, IORD | MWR, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);

        // reset in the middle of a store
        fetch_decode(6'h2B, 6'h00, 1'b0);
        tick("sw3_addr", ST_ADDR, ASA, 2'd2, 2'd0, 4'd0, 1'b0, 1'b0);
        tick("sw3_wait", ST_MEM_WR, IORD | MWR, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick("sw3_rst", ST_MEM_WR, 9'h0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick("sw3_after", ST_FETCH, MRD, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0);

        // sw timeout into sticky fault, cleared only by reset
        fetch_decode(6'h2B, 6'h00, 1'b0);
        tick("sw4_addr", ST_ADDR, ASA, 2'd2, 2'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            tick($sformatf("sw4_wait%0d", i), ST_MEM_WR, IORD | MWR,
                 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);
        chk("expire_state", state_o, 4'(ST_FAULT));
        chk("expire_fault", {3'b0, fault}, 4'd1);
        tick("fault0", ST_FAULT, 9'h0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b1);
        mem_ack = 1'b1;
        tick("fault1", ST_FAULT, 9'h0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b1);
        tick("fault2", ST_FAULT, 9'h0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b1);
        rst = 1'b1;
        tick("fault_rst", ST_FAULT, 9'h0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b1);
        rst = 1'b0;
        mem_ack = 1'b0;
        tick("fault_clr", ST_FETCH, MRD, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 8 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d records left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALUOP_W, default 4: ALU operation code width, minimum 4; codes zero-extended.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ack, range 1..255.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 opcode  input  6  instruction opcode from IR; func  input  6  function field.
REQ-006 zero  input  1  ALU equality flag; mem_ack  input  1  memory transfer complete.
REQ-007 ir_write, pc_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a  output  1 each: datapath strobes and mux selects.
REQ-008 alu_src_b  output  2  (0 reg, 1 const 4, 2 sign-ext imm, 3 shamt); pc_src  output  2  (0 PC+4, 1 branch target, 2 jump target).
REQ-009 alu_op  output  ALUOP_W  operation code; state_o  output  4  current state; illegal  output  1  one-cycle pulse; fault  output  1  sticky.

Function
REQ-010 States: FETCH, DECODE, EXEC_R, EXEC_SH, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_R, WB_MEM, BRANCH, JUMP, FAULT; outputs Moore, decoded from state and opcode/func latched in DECODE.
REQ-011 alu_op codes: add 0, sub 1, mul 2, and 3, or 4, slt 5, compare 7, sll 8, srl 10, clo 11, clz 12.
REQ-012 FETCH: mem_read=1, iord=0; on mem_ack: ir_write=1, pc_write=1, pc_src=0, next DECODE.
REQ-013 DECODE, one cycle: opcode 0 with func add/sub/and/or/slt -> EXEC_R; func sll/srl -> EXEC_SH; opcode 0x1C with func clo/clz/mul -> EXEC_R; addi/ori -> EXEC_I; lw/sw -> ADDR; bne -> BRANCH.
REQ-014 Any other opcode/func: illegal pulses 1 cycle, no strobe asserted, next FETCH.
REQ-015 EXEC_SH: alu_src_b=3 for both sll and srl; EXEC_R: alu_src_b=0; EXEC_I: alu_src_b=2; each -> WB_R next cycle.
REQ-016 WB_R: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type/0x1C, 0 for addi/ori; -> FETCH.
REQ-017 ADDR: alu_op=add, alu_src_b=2; lw -> MEM_RD, sw -> MEM_WR.
REQ-018 MEM_RD: iord=1, mem_read=1 until mem_ack -> WB_MEM (reg_write=1, mem_to_reg=1, reg_dst=0) -> FETCH.
REQ-019 MEM_WR: iord=1, mem_write=1 until mem_ack -> FETCH; reg_write never asserted for sw.
REQ-020 BRANCH: alu_op=compare; pc_write=1, pc_src=1 only when zero=0; -> FETCH.
REQ-021 Minimum latency with mem_ack in first cycle: bne 3, R/I/sw 4, lw 5 cycles.
REQ-022 Wait counter clears on entry to FETCH/MEM_RD/MEM_WR, increments per cycle without mem_ack; at MEM_TIMEOUT cycles without ack -> FAULT.
REQ-023 FAULT: all strobes 0, fault=1, remains until rst; mem_ack in the same cycle as timeout has priority (transfer completes).
REQ-024 At most one of mem_read/mem_write asserted in any cycle.

Reset
REQ-025 rst=1 at a clock edge: state FETCH, counter 0, latched opcode/func 0, fault 0; overrides all other events including mid-transfer.
REQ-026 While rst is high all strobes and illegal are 0 and alu_op is 0.

Configuration
REQ-027 JUMP_EN defined: opcode 0x02 -> JUMP state, pc_write=1, pc_src=2, -> FETCH (latency 3).
REQ-028 JUMP_EN undefined: opcode 0x02 treated as illegal per REQ-014; JUMP state absent.

Structure
REQ-029 Package mc_pkg holds state enumeration, opcode/func constants, alu_op codes, alu_src_b and pc_src encodings.
REQ-030 Sub-module mc_wait_timer implements the MEM_TIMEOUT counter with clear/expire ports.

Verification
REQ-031 add (op 0, func 0x20), ack immediate -> states FETCH,DECODE,EXEC_R,WB_R; reg_write=1, reg_dst=1, alu_op=0.
REQ-032 lw, ack delayed 3 cycles in MEM_RD -> mem_read,iord held 3 cycles, then WB_MEM with mem_to_reg=1; total 8 cycles.
REQ-033 bne with zero=0 then zero=1 -> pc_write/pc_src=1 only in first case.
REQ-034 sw with mem_ack never asserted, MEM_TIMEOUT=4 -> FAULT after 4 wait cycles, fault stays 1 until rst.
REQ-035 opcode 0x3F -> illegal pulse 1 cycle, no writes; opcode 0x02 -> jump taken with JUMP_EN, illegal pulse without.
REQ-036 rst asserted during MEM_WR -> next cycle FETCH, mem_write=0, fault=0.
